alu_rr_arbiter: RTL and testbench
=================================

# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one 4-bit, 2-bit-opcode ALU datapath (operands `a`, `b`, select `sel`, registered result `g`) between two requesters. It takes one request at a time, drives the ALU operand/select inputs from registers, and waits out the ALU latency. It then captures `g` and returns it to the winning requester with a one-cycle done pulse. It sits between the requesting control logic and the ALU instance.

## Interface
Parameters:
- `W`, 4, operand/result width
- `ALU_LAT`, 1, ALU latency in cycles: edges from the ALU sampling stable operands to `g` being valid

Ports:
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0`, `req1`  in  1  request from requester 0 / 1
- `a0`, `b0` / `a1`, `b1`  in  W  operands of requester 0 / 1, held stable while its req is high
- `sel0`, `sel1`  in  2  ALU operation select of requester 0 / 1
- `gnt0`, `gnt1`  out  1  one-cycle pulse: request accepted, operands latched
- `done0`, `done1`  out  1  one-cycle pulse: `res` holds this requester's result
- `res`  out  W  captured ALU result, held until next capture
- `busy`  out  1  high while an operation is in flight (state not IDLE)
- `alu_a`, `alu_b`  out  W  operands to the ALU (registered)
- `alu_sel`  out  2  select to the ALU (registered)
- `alu_g`  in  W  ALU result

## Operation
- States: IDLE, WAIT. `last` holds the most recently granted requester (1 bit).
- IDLE, no req: hold outputs, stay in IDLE.
- IDLE, exactly one req high: grant that requester.
- IDLE, both high: grant the requester != `last`.
- On grant edge:
  - load `alu_a`/`alu_b`/`alu_sel` from the winner's inputs.
  - assert the winner's `gnt` for one cycle.
  - set `last` to the winner.
  - load the down-counter with `ALU_LAT`.
  - go to WAIT.
- WAIT: the counter decrements each edge. On the edge where the counter is 0:
  - `res` <= `alu_g`.
  - pulse the matching `done`.
  - return to IDLE.
- Requests are ignored in WAIT. `gnt` is never asserted outside the IDLE→WAIT edge.
- A requester drops `req` on seeing `gnt`. A `req` still high once back in IDLE is a new request.
- `alu_a`/`alu_b`/`alu_sel` hold the last issued values between operations.
- `res` is `alu_g` unmodified, W bits. No extension or saturation.
- Reset (async, any state): state IDLE, `last`=1 (requester 0 wins first contention), counter 0. All outputs 0: `gnt*`, `done*`, `busy`, `res`, `alu_a`, `alu_b`, `alu_sel`.
- Reset mid-operation aborts the operation: no `done`, no `res` update.

## Timing
- Grant edge E (req sampled high in IDLE):
  - `gnt`, `busy` and `alu_*` are valid after E.
  - Capture edge is E+1+`ALU_LAT`. `done` and new `res` are valid after it, and `busy` falls after it.
- `ALU_LAT`=1: done one full cycle after the `gnt` cycle. Request→done = 2 edges after the grant.
- Earliest next grant is the capture edge +1. Sustained throughput is one op per `ALU_LAT`+2 cycles.
- `gnt` and `done` are always exactly one cycle wide and mutually exclusive between requesters.
- All outputs are registered. No combinational path from `req*`/`alu_g` to any output.

## Test plan
- Reset then idle: assert `reset` for 3 cycles at random phase. All outputs 0 during and after reset, `busy`=0, and no `gnt` for 20 idle cycles.
- Single op, `ALU_LAT`=1, bench ALU model g=a+b registered: `req0`, a0=5, b0=3, sel0=00.
  - `gnt0` pulses at grant edge E, with alu_a=5, alu_b=3, alu_sel=00 after E.
  - `done0` and res=8 after E+2, with `busy` high only between E and E+2.
- Contention: req0 and req1 rise together, a1=4'hF, b1=1 (model sum wraps to 0).
  - Requester 0 is granted first; `gnt1` at E+3.
  - `done1` with res=0 (4-bit wrap).
- Fairness: hold req0 and req1 continuously for 8 ops. Grants alternate 0,1,0,1…, never two consecutive to one side. Each op takes exactly 3 cycles.
- Reset mid-op: `reset` pulse in the WAIT cycle after `gnt1`. No `done1`, `res` stays 0, back in IDLE. The next contention grants requester 0.
- `ALU_LAT`=3 build with a 3-stage bench model: a0=5, b0=3, sel0=01. `done0` at E+4, `res` equals the model output for sel=01, and requests during WAIT are not granted.

Source files
------------

// File: rtl/alu_rr_arbiter_if.sv
// Request/grant/result bundle between the two requesters, the arbiter and the shared ALU.
interface alu_rr_arbiter_if #(
   parameter int unsigned W = 4
);
   logic         req0;
   logic         req1;
   logic [W-1:0] a0;
   logic [W-1:0] b0;
   logic [W-1:0] a1;
   logic [W-1:0] b1;
   logic [1:0]   sel0;
   logic [1:0]   sel1;
   logic         gnt0;
   logic         gnt1;
   logic         done0;
   logic         done1;
   logic [W-1:0] res;
   logic         busy;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [1:0]   alu_sel;
   logic [W-1:0] alu_g;

   modport slave (
      input  req0, req1, a0, b0, a1, b1, sel0, sel1, alu_g,
      output gnt0, gnt1, done0, done1, res, busy, alu_a, alu_b, alu_sel
   );

   modport master (
      output req0, req1, a0, b0, a1, b1, sel0, sel1, alu_g,
      input  gnt0, gnt1, done0, done1, res, busy, alu_a, alu_b, alu_sel
   );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin sequencer for a shared, fixed-latency ALU:
// grant, issue registered operands, wait ALU_LAT, capture the result and pulse done.
module alu_rr_arbiter #(
   parameter int unsigned W       = 4,
   parameter int unsigned ALU_LAT = 1
) (
   input logic             clk,
   input logic             reset,
   alu_rr_arbiter_if.slave bus
);
   localparam int unsigned CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state;
   logic          last;
   logic [CW-1:0] cnt;
   logic          any_req_c;
   logic          win_c;

   // Winner selection: a lone request wins, contention goes to whoever was not served last.
   always_comb begin
      any_req_c = bus.req0 | bus.req1;
      win_c     = bus.req1;
      if (bus.req0 && bus.req1) begin
         win_c = ~last;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last        <= 1'b1;
         cnt         <= '0;
         bus.gnt0    <= 1'b0;
         bus.gnt1    <= 1'b0;
         bus.done0   <= 1'b0;
         bus.done1   <= 1'b0;
         bus.busy    <= 1'b0;
         bus.res     <= '0;
         bus.alu_a   <= '0;
         bus.alu_b   <= '0;
         bus.alu_sel <= '0;
      end else begin
         bus.gnt0  <= 1'b0;
         bus.gnt1  <= 1'b0;
         bus.done0 <= 1'b0;
         bus.done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req_c) begin
                  state       <= WAIT;
                  last        <= win_c;
                  cnt         <= CW'(ALU_LAT);
                  bus.busy    <= 1'b1;
                  bus.gnt0    <= ~win_c;
                  bus.gnt1    <= win_c;
                  bus.alu_a   <= win_c ? bus.a1 : bus.a0;
                  bus.alu_b   <= win_c ? bus.b1 : bus.b0;
                  bus.alu_sel <= win_c ? bus.sel1 : bus.sel0;
               end
            end
            WAIT: begin
               // last doubles as the owner of the operation in flight
               if (cnt == '0) begin
                  state     <= IDLE;
                  bus.busy  <= 1'b0;
                  bus.res   <= bus.alu_g;
                  bus.done0 <= ~last;
                  bus.done1 <= last;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: one ALU_LAT=1 and one ALU_LAT=3 instance, each with a pipelined
// ALU model, a requester agent and a transaction-level expectation model compared every cycle.
module tb_alu_rr_arbiter;
   localparam int unsigned W  = 4;
   localparam int          NI = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int mode     = 0;   // 0 idle, 1 random, 2 both held high, 3 directed from d_*

   logic         d_req0 [NI];
   logic         d_req1 [NI];
   logic [W-1:0] d_a0   [NI];
   logic [W-1:0] d_b0   [NI];
   logic [W-1:0] d_a1   [NI];
   logic [W-1:0] d_b1   [NI];
   logic [1:0]   d_sel0 [NI];
   logic [1:0]   d_sel1 [NI];

   logic         s_gnt0  [NI];
   logic         s_gnt1  [NI];
   logic         s_done0 [NI];
   logic         s_done1 [NI];
   logic         s_busy  [NI];
   logic [W-1:0] s_res   [NI];
   logic [W-1:0] s_alu_a [NI];
   logic [W-1:0] s_alu_b [NI];
   logic [1:0]   s_sel   [NI];

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] sel);
      case (sel)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic pick(input logic r0, input logic r1, input logic last);
      return (r0 && r1) ? ~last : r1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   for (genvar k = 0; k < NI; k++) begin : g_i
      localparam int unsigned LAT = (k == 0) ? 1 : 3;

      alu_rr_arbiter_if #(.W(W)) bus ();

      alu_rr_arbiter #(.W(W), .ALU_LAT(LAT)) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );

      assign s_gnt0[k]  = bus.gnt0;
      assign s_gnt1[k]  = bus.gnt1;
      assign s_done0[k] = bus.done0;
      assign s_done1[k] = bus.done1;
      assign s_busy[k]  = bus.busy;
      assign s_res[k]   = bus.res;
      assign s_alu_a[k] = bus.alu_a;
      assign s_alu_b[k] = bus.alu_b;
      assign s_sel[k]   = bus.alu_sel;

      // ALU model: LAT register stages after the operand registers
      logic [W-1:0] pipe [LAT];
      always @(posedge clk) begin
         pipe[0] <= alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);
         for (int s = 1; s < int'(LAT); s++) pipe[s] <= pipe[s-1];
      end
      assign bus.alu_g = pipe[LAT-1];

      // Requester agent, driven away from the active edge
      always @(negedge clk) begin
         if (mode == 3) begin
            bus.req0 = d_req0[k]; bus.a0 = d_a0[k]; bus.b0 = d_b0[k]; bus.sel0 = d_sel0[k];
            bus.req1 = d_req1[k]; bus.a1 = d_a1[k]; bus.b1 = d_b1[k]; bus.sel1 = d_sel1[k];
         end else if (mode == 0) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
         end else begin
            if (bus.gnt0 || !bus.req0) begin
               bus.a0 = W'($urandom); bus.b0 = W'($urandom); bus.sel0 = 2'($urandom);
            end
            if (mode == 2)          bus.req0 = 1'b1;
            else if (bus.gnt0)      bus.req0 = 1'b0;
            else if (!bus.req0)     bus.req0 = ($urandom_range(2) == 0);
            if (bus.gnt1 || !bus.req1) begin
               bus.a1 = W'($urandom); bus.b1 = W'($urandom); bus.sel1 = 2'($urandom);
            end
            if (mode == 2)          bus.req1 = 1'b1;
            else if (bus.gnt1)      bus.req1 = 1'b0;
            else if (!bus.req1)     bus.req1 = ($urandom_range(2) == 0);
         end
      end

      // Expectation model in edge numbers: an accepted op is captured LAT+1 edges after its grant
      int           edge_n;
      int           end_edge;
      logic         m_last, m_win;
      logic [W-1:0] m_a, m_b, m_val, m_res;
      logic [1:0]   m_sel;
      logic         e_gnt0, e_gnt1, e_done0, e_done1, e_busy;
      logic         win_now;
      assign win_now = pick(bus.req0, bus.req1, m_last);

      always @(posedge clk or posedge reset) begin
         if (reset) begin
            edge_n <= 0; end_edge <= -1; m_last <= 1'b1; m_win <= 1'b0;
            m_a <= '0; m_b <= '0; m_sel <= '0; m_val <= '0; m_res <= '0;
            e_gnt0 <= 1'b0; e_gnt1 <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0; e_busy <= 1'b0;
         end else begin
            edge_n  <= edge_n + 1;
            e_gnt0  <= 1'b0; e_gnt1 <= 1'b0; e_done0 <= 1'b0; e_done1 <= 1'b0;
            if (end_edge < 0) begin
               if (bus.req0 || bus.req1) begin
                  m_win    <= win_now;
                  m_last   <= win_now;
                  m_a      <= win_now ? bus.a1 : bus.a0;
                  m_b      <= win_now ? bus.b1 : bus.b0;
                  m_sel    <= win_now ? bus.sel1 : bus.sel0;
                  m_val    <= win_now ? alu_f(bus.a1, bus.b1, bus.sel1)
                                      : alu_f(bus.a0, bus.b0, bus.sel0);
                  e_gnt0   <= ~win_now;
                  e_gnt1   <= win_now;
                  e_busy   <= 1'b1;
                  end_edge <= edge_n + 2 + int'(LAT);
               end
            end else if (edge_n + 1 == end_edge) begin
               m_res    <= m_val;
               e_done0  <= ~m_win;
               e_done1  <= m_win;
               e_busy   <= 1'b0;
               end_edge <= -1;
            end
         end
      end

      always @(negedge clk) begin
         check($sformatf("lat%0d_outputs", LAT),
               32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy,
                    bus.res, bus.alu_a, bus.alu_b, bus.alu_sel}),
               32'({e_gnt0, e_gnt1, e_done0, e_done1, e_busy, m_res, m_a, m_b, m_sel}));
      end
   end

   task automatic pulse_reset(input int cycles);
      @(posedge clk);
      #($urandom_range(1, 4));
      reset = 1'b1;
      #1;
      for (int i = 0; i < NI; i++) begin
         check($sformatf("in_reset_outputs_%0d", i),
               32'({s_gnt0[i], s_gnt1[i], s_done0[i], s_done1[i], s_busy[i],
                    s_res[i], s_alu_a[i], s_alu_b[i], s_sel[i]}), 32'd0);
      end
      repeat (cycles) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   task automatic wait_gnt(input int i, input bit side, input string name);
      int n;
      n = 0;
      step();
      while (!(side ? s_gnt1[i] : s_gnt0[i]) && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         checks++;
         failures++;
         $display("FAIL %s: grant missing after 20 cycles", name);
      end
   endtask

   task automatic clear_dir();
      for (int i = 0; i < NI; i++) begin
         d_req0[i] = 1'b0; d_req1[i] = 1'b0;
         d_a0[i] = '0; d_b0[i] = '0; d_a1[i] = '0; d_b1[i] = '0;
         d_sel0[i] = '0; d_sel1[i] = '0;
      end
   endtask

   initial begin
      int n;
      int side [8];
      int t    [8];
      int cyc;
      clear_dir();
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;

      // Reset at random phase, then idle
      pulse_reset(3);
      check("post_reset_busy", 32'(s_busy[0]), 32'd0);
      check("post_reset_res", 32'(s_res[0]), 32'd0);
      n = 0;
      repeat (20) begin
         step();
         n += int'(s_gnt0[0]) + int'(s_gnt1[0]) + int'(s_gnt0[1]) + int'(s_gnt1[1]);
      end
      check("idle_grants", 32'(n), 32'd0);

      // Single op on the ALU_LAT=1 instance: 5 + 3
      mode = 3;
      d_a0[0] = 4'd5; d_b0[0] = 4'd3; d_sel0[0] = 2'd0; d_req0[0] = 1'b1;
      wait_gnt(0, 1'b0, "single_gnt0");
      check("single_alu", 32'({s_alu_a[0], s_alu_b[0], s_sel[0], s_busy[0]}), 32'({4'd5, 4'd3, 2'd0, 1'b1}));
      d_req0[0] = 1'b0;
      step();
      check("single_wait", 32'({s_gnt0[0], s_done0[0], s_busy[0]}), 32'b001);
      step();
      check("single_done", 32'({s_done0[0], s_busy[0], s_res[0]}), 32'({1'b1, 1'b0, 4'd8}));
      step();
      check("single_after", 32'({s_done0[0], s_busy[0]}), 32'b00);

      // Contention from reset: requester 0 first, then 1 with a wrapping sum
      pulse_reset(3);
      d_a0[0] = 4'd2; d_b0[0] = 4'd6; d_sel0[0] = 2'd0;
      d_a1[0] = 4'hF; d_b1[0] = 4'd1; d_sel1[0] = 2'd0;
      d_req0[0] = 1'b1; d_req1[0] = 1'b1;
      wait_gnt(0, 1'b0, "cont_gnt0");
      check("cont_first", 32'({s_gnt0[0], s_gnt1[0]}), 32'b10);
      d_req0[0] = 1'b0;
      step();
      step();
      check("cont_done0", 32'({s_done0[0], s_res[0]}), 32'({1'b1, 4'd8}));
      step();
      check("cont_gnt1_e3", 32'({s_gnt0[0], s_gnt1[0]}), 32'b01);
      d_req1[0] = 1'b0;
      step();
      step();
      check("cont_done1_wrap", 32'({s_done1[0], s_res[0]}), 32'({1'b1, 4'd0}));
      clear_dir();
      repeat (8) step();

      // Fairness with both requests held high
      mode = 2;
      n = 0;
      cyc = 0;
      for (int c = 0; c < 60 && n < 8; c++) begin
         step();
         cyc++;
         if (s_gnt0[0] || s_gnt1[0]) begin
            side[n] = int'(s_gnt1[0]);
            t[n]    = cyc;
            n++;
         end
      end
      check("fair_count", 32'(n), 32'd8);
      for (int i = 1; i < n; i++) begin
         check($sformatf("fair_alt_%0d", i), 32'(side[i] ^ side[i-1]), 32'd1);
         check($sformatf("fair_period_%0d", i), 32'(t[i] - t[i-1]), 32'd3);
      end
      mode = 3;
      repeat (10) step();

      // Reset in the WAIT cycle after gnt1 aborts the op
      d_a1[0] = 4'd7; d_b1[0] = 4'd7; d_sel1[0] = 2'd0; d_req1[0] = 1'b1;
      wait_gnt(0, 1'b1, "abort_gnt1");
      d_req1[0] = 1'b0;
      step();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n = 0;
      repeat (4) begin
         step();
         n += int'(s_done1[0]) + int'(s_busy[0]) + int'(s_res[0] != '0);
      end
      check("abort_no_done", 32'(n), 32'd0);
      d_req0[0] = 1'b1; d_req1[0] = 1'b1;
      wait_gnt(0, 1'b0, "abort_next_gnt0");
      check("abort_next_winner", 32'({s_gnt0[0], s_gnt1[0]}), 32'b10);
      clear_dir();
      repeat (8) step();

      // ALU_LAT=3 instance: 5 - 3, request from the other side during WAIT
      d_a0[1] = 4'd5; d_b0[1] = 4'd3; d_sel0[1] = 2'd1; d_req0[1] = 1'b1;
      wait_gnt(1, 1'b0, "lat3_gnt0");
      check("lat3_alu", 32'({s_alu_a[1], s_alu_b[1], s_sel[1]}), 32'({4'd5, 4'd3, 2'd1}));
      d_req0[1] = 1'b0;
      d_a1[1] = 4'd1; d_b1[1] = 4'd1; d_sel1[1] = 2'd0; d_req1[1] = 1'b1;
      n = 0;
      repeat (3) begin
         step();
         n += int'(s_gnt1[1]) + int'(s_done0[1]);
      end
      check("lat3_wait_quiet", 32'(n), 32'd0);
      step();
      check("lat3_done_e4", 32'({s_done0[1], s_gnt1[1], s_res[1]}), 32'({1'b1, 1'b0, 4'd2}));
      step();
      check("lat3_next_gnt1", 32'(s_gnt1[1]), 32'd1);
      clear_dir();
      repeat (10) step();

      // Random traffic with one asynchronous reset in the middle
      mode = 1;
      repeat (200) step();
      pulse_reset(2);
      repeat (200) step();
      mode = 0;
      repeat (20) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
